// File: rtl/mp_reg_file.sv
// Byte-lane writable register file with two registered read ports, write-first bypass
// and a self-timed clear sweep that runs after reset or on request.
module mp_reg_file #(
    parameter int WordLength = 16,
    parameter int AddrBits   = 3,
    parameter int ByteWidth  = 8,
    parameter logic [WordLength-1:0] InitValue = '0,
    localparam int NumLanes  = WordLength / ByteWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  wr_en_i,
    input  logic [AddrBits-1:0]   w_addr_i,
    input  logic [NumLanes-1:0]   w_be_i,
    input  logic [WordLength-1:0] w_data_i,
    input  logic                  rd_en_a_i,
    input  logic                  rd_en_b_i,
    input  logic [AddrBits-1:0]   r_addr_a_i,
    input  logic [AddrBits-1:0]   r_addr_b_i,
    output logic [WordLength-1:0] r_data_a_o,
    output logic [WordLength-1:0] r_data_b_o,
    output logic                  busy_o
);

    localparam int Depth = 2 ** AddrBits;
    localparam logic [AddrBits-1:0] LastAddr = AddrBits'(Depth - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state_q, state_d;
    logic [AddrBits-1:0] clr_cnt_q, clr_cnt_d;
    logic                busy_q, busy_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // The counter wraps to zero on the same edge that leaves CLEAR.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LastAddr) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (clear_i) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
        busy_d = (state_d == CLEAR);
    end

    assign busy_o = busy_q;

    logic                clear_we;
    logic                user_ok;
    logic [AddrBits-1:0] mem_waddr;

    assign clear_we  = (state_q == CLEAR) && !rst_i;
    assign user_ok   = (state_q == READY) && !rst_i;
    assign mem_waddr = clear_we ? clr_cnt_q : w_addr_i;

    // One independent memory per byte lane so each lane keeps a single write port.
    generate
        for (genvar gi = 0; gi < NumLanes; gi++) begin : g_lane
            logic [ByteWidth-1:0] mem_lane [Depth];
            logic [ByteWidth-1:0] rd_a_q, rd_b_q;
            logic                 lane_we;
            logic [ByteWidth-1:0] lane_wdata;
            logic                 hit_a, hit_b;

            assign lane_we    = clear_we || (user_ok && wr_en_i && w_be_i[gi]);
            assign lane_wdata = clear_we ? InitValue[gi*ByteWidth +: ByteWidth]
                                         : w_data_i[gi*ByteWidth +: ByteWidth];
            assign hit_a = wr_en_i && w_be_i[gi] && (w_addr_i == r_addr_a_i);
            assign hit_b = wr_en_i && w_be_i[gi] && (w_addr_i == r_addr_b_i);

            always_ff @(posedge clk_i) begin
                if (lane_we) begin
                    mem_lane[mem_waddr] <= lane_wdata;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rd_a_q <= '0;
                    rd_b_q <= '0;
                end else if (user_ok) begin
                    if (rd_en_a_i) begin
                        rd_a_q <= hit_a ? w_data_i[gi*ByteWidth +: ByteWidth] : mem_lane[r_addr_a_i];
                    end
                    if (rd_en_b_i) begin
                        rd_b_q <= hit_b ? w_data_i[gi*ByteWidth +: ByteWidth] : mem_lane[r_addr_b_i];
                    end
                end
            end

            assign r_data_a_o[gi*ByteWidth +: ByteWidth] = rd_a_q;
            assign r_data_b_o[gi*ByteWidth +: ByteWidth] = rd_b_q;
        end
    endgenerate

endmodule

// File: tb/tb_mp_reg_file.sv
// Randomized and directed bench for mp_reg_file against a cycle-level behavioural model
// that tracks remaining sweep cycles and the array contents as plain arrays.
module tb_mp_reg_file;

    logic        clk_i = 1'b0;
    logic        rst_i, clear_i, wr_en_i, rd_en_a_i, rd_en_b_i;
    logic [2:0]  w_addr_i, r_addr_a_i, r_addr_b_i;
    logic [1:0]  w_be_i;
    logic [15:0] w_data_i;
    logic [15:0] r_data_a_o, r_data_b_o;
    logic        busy_o;

    mp_reg_file #(.WordLength(16), .AddrBits(3), .ByteWidth(8), .InitValue(16'h0000)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .wr_en_i(wr_en_i),
        .w_addr_i(w_addr_i), .w_be_i(w_be_i), .w_data_i(w_data_i),
        .rd_en_a_i(rd_en_a_i), .rd_en_b_i(rd_en_b_i),
        .r_addr_a_i(r_addr_a_i), .r_addr_b_i(r_addr_b_i),
        .r_data_a_o(r_data_a_o), .r_data_b_o(r_data_b_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [8];
    logic [15:0] ref_ra, ref_rb;
    int          sweep_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lane_mask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

    // One clock: advance the model from the driven inputs, then compare outputs.
    task automatic step(input string tag);
        logic [15:0] merged;
        @(posedge clk_i);
        if (rst_i) begin
            sweep_left = 8;
            ref_ra = 16'h0;
            ref_rb = 16'h0;
        end else if (sweep_left > 0) begin
            ref_mem[8 - sweep_left] = 16'h0000;
            sweep_left--;
        end else begin
            merged = (ref_mem[w_addr_i] & ~lane_mask(w_be_i)) | (w_data_i & lane_mask(w_be_i));
            if (rd_en_a_i) ref_ra = (wr_en_i && r_addr_a_i == w_addr_i) ? merged : ref_mem[r_addr_a_i];
            if (rd_en_b_i) ref_rb = (wr_en_i && r_addr_b_i == w_addr_i) ? merged : ref_mem[r_addr_b_i];
            if (wr_en_i) ref_mem[w_addr_i] = merged;
            if (clear_i) sweep_left = 8;
        end
        #1;
        $display("%s rst=%0b clr=%0b wr=%0b wa=%0d be=%b wd=%h ra=%0d/%0b rb=%0d/%0b -> A=%h B=%h busy=%0b",
                 tag, rst_i, clear_i, wr_en_i, w_addr_i, w_be_i, w_data_i,
                 r_addr_a_i, rd_en_a_i, r_addr_b_i, rd_en_b_i, r_data_a_o, r_data_b_o, busy_o);
        check({tag, "_busy"}, 32'(busy_o), 32'(sweep_left > 0));
        check({tag, "_ra"}, 32'(r_data_a_o), 32'(ref_ra));
        check({tag, "_rb"}, 32'(r_data_b_o), 32'(ref_rb));
    endtask

    task automatic idle();
        rst_i = 0; clear_i = 0; wr_en_i = 0; rd_en_a_i = 0; rd_en_b_i = 0;
        w_addr_i = 0; w_be_i = 0; w_data_i = 0; r_addr_a_i = 0; r_addr_b_i = 0;
    endtask

    task automatic op(input string tag, input logic wr, input logic [2:0] wa, input logic [1:0] be,
                      input logic [15:0] wd, input logic ea, input logic [2:0] ra,
                      input logic eb, input logic [2:0] rb, input logic clr);
        wr_en_i = wr; w_addr_i = wa; w_be_i = be; w_data_i = wd;
        rd_en_a_i = ea; r_addr_a_i = ra; rd_en_b_i = eb; r_addr_b_i = rb; clear_i = clr;
        step(tag);
        idle();
    endtask

    task automatic measure_sweep(input string tag);
        int n = 0;
        while (n < 20) begin
            step(tag);
            n++;
            if (!busy_o) break;
        end
        check({tag, "_len"}, 32'(n), 32'd8);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0;
        ref_ra = 0; ref_rb = 0; sweep_left = 8;
        idle();
        rst_i = 1;
        step("reset");
        step("reset");
        check("reset_ra_zero", 32'(r_data_a_o), 32'h0);
        rst_i = 0;
        measure_sweep("init_sweep");

        for (int i = 0; i < 8; i++) begin
            op("rd_all", 0, 0, 0, 0, 1, 3'(i), 1, 3'(i), 0);
            check("rd_all_zero", 32'(r_data_a_o), 32'h0);
        end

        op("wr5", 1, 5, 2'b11, 16'hA1B2, 0, 0, 0, 0, 0);
        op("wr5lo", 1, 5, 2'b01, 16'hFFFF, 0, 0, 0, 0, 0);
        op("rd5", 0, 0, 0, 0, 1, 5, 0, 0, 0);
        check("rd5_value", 32'(r_data_a_o), 32'hA1FF);

        op("bypass3", 1, 3, 2'b10, 16'h1234, 1, 3, 1, 3, 0);
        check("bypass3_a", 32'(r_data_a_o), 32'h1200);
        check("bypass3_b", 32'(r_data_b_o), 32'h1200);

        op("hold_a0", 0, 0, 0, 0, 0, 1, 0, 2, 0);
        op("hold_a1", 0, 0, 0, 0, 0, 6, 0, 7, 0);
        check("hold_a", 32'(r_data_a_o), 32'h1200);
        op("be0_wr", 1, 5, 2'b00, 16'h0000, 0, 0, 0, 0, 0);
        op("be0_rd", 0, 0, 0, 0, 1, 5, 0, 0, 0);
        check("be0_value", 32'(r_data_a_o), 32'hA1FF);

        for (int i = 0; i < 8; i++) op("fill", 1, 3'(i), 2'b11, 16'h5A5A, 0, 0, 0, 0, 0);
        op("clr_pulse", 0, 0, 0, 0, 1, 2, 1, 4, 1);
        check("clr_pulse_rd", 32'(r_data_a_o), 32'h5A5A);
        for (int i = 0; i < 8; i++) begin
            op("busy_ops", 1, 3'(i), 2'b11, 16'hBEEF, 1, 3'(7 - i), 1, 3'(i), 0);
            check("busy_hold_a", 32'(r_data_a_o), 32'h5A5A);
        end
        check("post_clear_busy", 32'(busy_o), 32'h0);
        for (int i = 0; i < 8; i++) begin
            op("rd_cleared", 0, 0, 0, 0, 1, 3'(i), 1, 3'(7 - i), 0);
            check("cleared_a", 32'(r_data_a_o), 32'h0);
        end

        op("fill7", 1, 7, 2'b11, 16'hC3C3, 0, 0, 0, 0, 0);
        op("clr2", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) op("sweep4", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1;
        step("mid_rst");
        check("mid_rst_busy", 32'(busy_o), 32'h1);
        rst_i = 0;
        measure_sweep("restart_sweep");

        for (int i = 0; i < 1500; i++) begin
            rst_i      = ($urandom_range(0, 299) == 0);
            clear_i    = ($urandom_range(0, 39) == 0);
            wr_en_i    = $urandom_range(0, 1);
            w_addr_i   = 3'($urandom_range(0, 7));
            w_be_i     = 2'($urandom_range(0, 3));
            w_data_i   = 16'($urandom);
            rd_en_a_i  = $urandom_range(0, 1);
            rd_en_b_i  = $urandom_range(0, 1);
            r_addr_a_i = ($urandom_range(0, 3) == 0) ? w_addr_i : 3'($urandom_range(0, 7));
            r_addr_b_i = ($urandom_range(0, 3) == 0) ? r_addr_a_i : 3'($urandom_range(0, 7));
            step("rand");
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp_reg_file.md
MP_REG_FILE -- requirements
Module: mp_reg_file

Interface
REQ-001 SHALL have parameter WordLength, default 16, data word width in bits.
REQ-002 SHALL have parameter AddrBits, default 3, address width; depth is 2**AddrBits.
REQ-003 SHALL have parameter ByteWidth, default 8, byte-lane width; WordLength SHALL be an integer multiple of ByteWidth (NumLanes = WordLength/ByteWidth).
REQ-004 SHALL have parameter InitValue, default 0, WordLength-bit value written to every entry by a clear sweep.
REQ-005 SHALL have the following ports:
- clk_i  input  1  sole clock, all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- clear_i  input  1  request a full-array clear sweep.
- wr_en_i  input  1  write enable.
- w_addr_i  input  AddrBits  write address.
- w_be_i  input  NumLanes  per-lane write byte enable.
- w_data_i  input  WordLength  write data.
- rd_en_a_i / rd_en_b_i  input  1  read enable, ports A and B.
- r_addr_a_i / r_addr_b_i  input  AddrBits  read addresses.
- r_data_a_o / r_data_b_o  output  WordLength  registered read data.
- busy_o  output  1  clear sweep in progress; user ops ignored.

Function
REQ-006 SHALL implement an FSM with states CLEAR and READY.
REQ-007 In CLEAR, SHALL write InitValue (all lanes) to address clr_cnt each cycle, with clr_cnt incrementing from 0 to 2**AddrBits-1.
REQ-008 SHALL transition CLEAR->READY on the cycle the write to address 2**AddrBits-1 occurs; a sweep lasts exactly 2**AddrBits cycles.
REQ-009 In READY, clear_i=1 SHALL transition to CLEAR with clr_cnt=0 on the next edge; clear_i in CLEAR SHALL be ignored (no restart).
REQ-010 busy_o SHALL be registered and equal 1 exactly while the state is CLEAR.
REQ-011 In CLEAR, wr_en_i, rd_en_a_i and rd_en_b_i SHALL be ignored; r_data_a_o/r_data_b_o SHALL hold their values.
REQ-012 In READY with wr_en_i=1, SHALL update only the lanes of entry w_addr_i whose w_be_i bit is 1; other lanes SHALL keep their value.
REQ-013 In READY with wr_en_i=1 and w_be_i all zero, the array SHALL be unchanged.
REQ-014 In READY, rd_en_x_i=1 SHALL load r_data_x_o with entry r_addr_x_i on the next edge (latency 1); with rd_en_x_i=0, r_data_x_o SHALL hold.
REQ-015 On a same-cycle read and write to the same address (write-first bypass), r_data_x_o SHALL equal the merged word: w_data_i lanes where w_be_i=1, old entry lanes elsewhere.
REQ-016 Ports A and B SHALL be independent; both reading the same address in one cycle SHALL return identical data.
REQ-017 In READY, a clear_i=1 cycle that also carries wr_en_i/rd_en SHALL still perform that write/read; the sweep starts on the following cycle.
REQ-018 clr_cnt SHALL be AddrBits wide, and its wrap from 2**AddrBits-1 to 0 SHALL coincide with the exit from CLEAR.

Reset
REQ-019 While rst_i=1 at a rising edge, state SHALL become CLEAR, clr_cnt 0, busy_o 1, r_data_a_o and r_data_b_o 0.
REQ-020 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from address 0; array contents need not be reset directly.
REQ-021 After rst_i deasserts, busy_o SHALL stay 1 for exactly 2**AddrBits cycles, then fall to 0.

Verification (WordLength=16, AddrBits=3, ByteWidth=8, InitValue=16'h0000)
REQ-022 Reset 2 cycles, release -> busy_o=1 for 8 cycles, then 0; reading all 8 addresses on A and B returns 16'h0000; r_data_* are 0 during reset.
REQ-023 Write addr 5 data 16'hA1B2 be 2'b11, then addr 5 data 16'hFFFF be 2'b01, read A addr 5 -> 16'hA1FF one cycle after the read.
REQ-024 Same cycle: write addr 3 data 16'h1234 be 2'b10 (old 16'h0000), read A and B addr 3 -> both 16'h1200 next cycle.
REQ-025 Fill all 8 entries with 16'h5A5A, pulse clear_i -> busy_o=1 for 8 cycles; writes/reads issued during busy ignored and r_data held; afterwards all entries 16'h0000.
REQ-026 Assert rst_i at sweep cycle 4 -> busy_o stays 1 and the sweep restarts at address 0, finishing 8 cycles after rst_i deasserts.
REQ-027 rd_en_a_i=0 with a changing r_addr_a_i -> r_data_a_o holds its previous value; a write with be 2'b00 leaves the entry unchanged.
